// File: rtl/span_cme_pkg.sv
// Shared constants and types for the span_cme parameter loader slice.
package span_cme_pkg;

  localparam int SPAN_NUM_REGS      = 34;
  localparam int SPAN_DATA_W        = 16;
  localparam int SPAN_ADDR_W        = 6;
  localparam int SPAN_RESULT_OFFSET = 34;

  typedef enum logic [2:0] {
    LOAD,
    ISSUE,
    WAIT,
    READ,
    CAPTURE,
    RESULT
  } loader_state_t;

  typedef logic signed [SPAN_DATA_W-1:0] span_word_t;

endpackage

// File: rtl/span_param_buf.sv
// Frame buffer: one synchronous write port, one combinational read port.
module span_param_buf #(
  parameter int NUM_REGS = 34,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_idx] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/span_param_loader.sv
// Buffers one SPAN parameter frame, replays it into span_cme, waits, reads
// the result back and offers it on a valid/ready port.
module span_param_loader
  import span_cme_pkg::*;
#(
  parameter int NUM_REGS      = SPAN_NUM_REGS,
  parameter int DATA_W        = SPAN_DATA_W,
  parameter int ADDR_W        = SPAN_ADDR_W,
  parameter int CALC_CYCLES   = 200,
  parameter int RESULT_OFFSET = SPAN_RESULT_OFFSET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] writeData,
  output logic [ADDR_W-1:0] offset,
  output logic              write,
  output logic              chipselect,
  output logic              read,
  input  logic [DATA_W-1:0] readData,
  input  logic [15:0]       priceScanRange,
  output logic [15:0]       r_scan,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [15:0]      WAIT_LAST = 16'(CALC_CYCLES - 1);

  loader_state_t r_state, w_state_nxt;

  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [IDX_W-1:0]  r_k, w_k_nxt;
  logic [15:0]       r_wait, w_wait_nxt;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_first_word;
  logic              w_accept;

  logic              r_s_ready, w_s_ready_nxt;
  logic              r_write, w_write_nxt;
  logic              r_cs, w_cs_nxt;
  logic              r_read, w_read_nxt;
  logic [ADDR_W-1:0] r_offset, w_offset_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              w_rvalid_nxt;
  logic [15:0]       w_scan_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              r_err, w_err_nxt;
  logic              r_busy, w_busy_nxt;

  assign w_accept = s_valid && r_s_ready;

  // Read port looks one word ahead so writeData is registered alongside offset.
  assign w_rd_idx = (r_state == ISSUE && r_k != LAST_IDX) ? r_k + 1'b1 : '0;
  // Only a one-word frame finishes at idx 0; its word is not in the buffer yet.
  assign w_first_word = (r_idx == '0) ? s_data : w_rd_data;

  span_param_buf #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_buf (
    .clk       (clk),
    .i_we      (w_accept),
    .i_wr_idx  (r_idx),
    .i_wr_data (s_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_k_nxt      = r_k;
    w_wait_nxt   = r_wait;
    w_write_nxt  = 1'b0;
    w_cs_nxt     = 1'b0;
    w_read_nxt   = 1'b0;
    w_offset_nxt = r_offset;
    w_wdata_nxt  = r_wdata;
    w_rvalid_nxt = 1'b0;
    w_scan_nxt   = r_scan;
    w_rdata_nxt  = r_data;
    w_err_nxt    = 1'b0;

    case (r_state)
      LOAD: begin
        if (w_accept) begin
          if ((r_idx == LAST_IDX) != s_last) begin
            w_err_nxt = 1'b1;
            w_idx_nxt = '0;
          end else if (s_last) begin
            w_state_nxt  = ISSUE;
            w_idx_nxt    = '0;
            w_k_nxt      = '0;
            w_write_nxt  = 1'b1;
            w_cs_nxt     = 1'b1;
            w_offset_nxt = '0;
            w_wdata_nxt  = w_first_word;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (r_k == LAST_IDX) begin
          w_state_nxt = WAIT;
          w_wait_nxt  = '0;
        end else begin
          w_k_nxt      = r_k + 1'b1;
          w_write_nxt  = 1'b1;
          w_cs_nxt     = 1'b1;
          w_offset_nxt = ADDR_W'(w_rd_idx);
          w_wdata_nxt  = w_rd_data;
        end
      end
      WAIT: begin
        if (r_wait == WAIT_LAST) begin
          w_state_nxt  = READ;
          w_read_nxt   = 1'b1;
          w_cs_nxt     = 1'b1;
          w_offset_nxt = ADDR_W'(RESULT_OFFSET);
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      READ: begin
        w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        w_state_nxt  = RESULT;
        w_rvalid_nxt = 1'b1;
        w_scan_nxt   = priceScanRange;
        w_rdata_nxt  = readData;
      end
      RESULT: begin
        if (r_ready) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
        end else begin
          w_rvalid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_idx_nxt   = '0;
      end
    endcase

    w_s_ready_nxt = (w_state_nxt == LOAD);
    w_busy_nxt    = (w_state_nxt != LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= LOAD;
      r_idx     <= '0;
      r_k       <= '0;
      r_wait    <= '0;
      r_s_ready <= 1'b1;
      r_write   <= 1'b0;
      r_cs      <= 1'b0;
      r_read    <= 1'b0;
      r_offset  <= '0;
      r_wdata   <= '0;
      r_valid   <= 1'b0;
      r_scan    <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_k       <= w_k_nxt;
      r_wait    <= w_wait_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_write   <= w_write_nxt;
      r_cs      <= w_cs_nxt;
      r_read    <= w_read_nxt;
      r_offset  <= w_offset_nxt;
      r_wdata   <= w_wdata_nxt;
      r_valid   <= w_rvalid_nxt;
      r_scan    <= w_scan_nxt;
      r_data    <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign s_ready    = r_s_ready;
  assign write      = r_write;
  assign chipselect = r_cs;
  assign read       = r_read;
  assign offset     = r_offset;
  assign writeData  = r_wdata;
  assign err        = r_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_span_param_loader.sv
// Directed/randomised bench for span_param_loader with a span_cme stand-in.
module tb_span_param_loader;

  localparam int NREG = 34;
  localparam int CALC = 200;
  localparam int ROFF = 34;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid, s_last;
  logic        s_ready;
  logic [15:0] writeData;
  logic [5:0]  offset;
  logic        write, chipselect, read;
  logic [15:0] readData = '0;
  logic [15:0] priceScanRange = '0;
  logic [15:0] r_scan, r_data;
  logic        r_valid, r_ready;
  logic        err, busy;

  span_param_loader #(
    .NUM_REGS      (NREG),
    .DATA_W        (16),
    .ADDR_W        (6),
    .CALC_CYCLES   (CALC),
    .RESULT_OFFSET (ROFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .writeData      (writeData),
    .offset         (offset),
    .write          (write),
    .chipselect     (chipselect),
    .read           (read),
    .readData       (readData),
    .priceScanRange (priceScanRange),
    .r_scan         (r_scan),
    .r_data         (r_data),
    .r_valid        (r_valid),
    .r_ready        (r_ready),
    .err            (err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observation logs and span_cme stand-in.
  logic [31:0] wq [$];
  int          wcyc [$];
  int          rcyc [$];
  int          roff [$];
  int          rvcyc [$];
  logic [15:0] rv_data_q [$];
  logic [15:0] rv_scan_q [$];
  logic [15:0] exp_tok_q [$];
  logic [15:0] exp_scan_q [$];
  int          errcnt = 0;
  int          badcnt = 0;
  logic        rd_pending = 1'b0;
  logic        rv_prev = 1'b0;
  logic [15:0] rd_tok = '0;
  logic [15:0] scan_v;

  always @(negedge clk) begin
    scan_v = 16'($urandom);
    priceScanRange = scan_v;
    if (rd_pending) begin
      readData = rd_tok;
      exp_tok_q.push_back(rd_tok);
      exp_scan_q.push_back(scan_v);
    end else begin
      readData = 16'($urandom);
    end
    rd_pending = 1'b0;
    if (write) begin
      wq.push_back({10'd0, offset, writeData});
      wcyc.push_back(cyc);
      if (!chipselect || read) badcnt++;
    end
    if (read) begin
      rcyc.push_back(cyc);
      roff.push_back(int'(offset));
      if (!chipselect) badcnt++;
      rd_pending = 1'b1;
      rd_tok = 16'($urandom);
    end
    if (r_valid && !rv_prev) begin
      rvcyc.push_back(cyc);
      rv_data_q.push_back(r_data);
      rv_scan_q.push_back(r_scan);
    end
    rv_prev = r_valid;
    if (err) errcnt++;
  end

  int n_pass = 0;
  int n_total = 0;
  int acc_cyc = 0;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send_word(input logic [15:0] d, input logic last, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    for (int t = 0; t < 100; t++) begin
      if (s_ready) begin
        acc_cyc = cyc;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check_int("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [15:0] f [NREG], input int gap_max);
    for (int k = 0; k < NREG; k++) send_word(f[k], k == NREG - 1, gap_max);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_result(input int nrv);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      #1;
      if (rvcyc.size() > nrv) return;
    end
    check_int("result_timeout", 0, 1);
  endtask

  // Expected behaviour: words replayed at offsets 0..N-1 on consecutive
  // cycles starting one cycle after the final accept, read CALC idle cycles
  // after the last write, result valid N+CALC+2 cycles after the first write.
  task automatic check_frame(input string nm, input logic [15:0] f [NREG],
                             input int base, input int nrd, input int nrv);
    int gaps;
    check_int({nm, "_write_count"}, wq.size() - base, NREG);
    if (wq.size() >= base + NREG) begin
      for (int k = 0; k < NREG; k++)
        check_vec($sformatf("%s_write%0d", nm, k), 64'(wq[base+k]), {42'd0, 6'(k), f[k]});
      gaps = 0;
      for (int k = 1; k < NREG; k++)
        if (wcyc[base+k] != wcyc[base] + k) gaps++;
      check_int({nm, "_write_gaps"}, gaps, 0);
      check_int({nm, "_first_write_lat"}, wcyc[base] - acc_cyc, 1);
    end
    check_int({nm, "_read_count"}, rcyc.size() - nrd, 1);
    if (rcyc.size() > nrd && rvcyc.size() > nrv && wq.size() >= base + NREG) begin
      check_int({nm, "_read_gap"}, rcyc[nrd] - wcyc[base+NREG-1], CALC + 1);
      check_int({nm, "_read_offset"}, roff[nrd], ROFF);
      check_int({nm, "_rvalid_lat"}, rvcyc[nrv] - wcyc[base], NREG + CALC + 2);
      check_int({nm, "_rvalid_after_read"}, rvcyc[nrv] - rcyc[nrd], 2);
      check_vec({nm, "_r_data"}, 64'(rv_data_q[nrv]), 64'(exp_tok_q[nrd]));
      check_vec({nm, "_r_scan"}, 64'(rv_scan_q[nrv]), 64'(exp_scan_q[nrd]));
    end
  endtask

  logic [15:0] port [NREG] = '{
    16'd96, 16'd10, 16'd15, 16'hFFF6, 16'hFFEC, 16'd5, 16'd10, 16'd0, 16'd0, 16'd3,
    16'd1, 16'd5, 16'd1, 16'd3, 16'd5, 16'd0, 16'd0, 16'd2, 16'd4, 16'd6,
    16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd100, 16'd100, 16'd110, 16'd120, 16'd1750,
    16'd2500, 16'd2, 16'd1, 16'd55};
  logic [15:0] rf [NREG];
  int base, nrd, nrv, e0;

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    r_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("reset_ctrl", 64'({s_ready, write, chipselect, read, r_valid, err, busy}), 64'(7'b1000000));
    check_vec("reset_offset", 64'(offset), 64'd0);
    check_vec("reset_wdata", 64'(writeData), 64'd0);
    check_vec("reset_r_scan", 64'(r_scan), 64'd0);
    check_vec("reset_r_data", 64'(r_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Portfolio frame replay and result timing, consumer always ready.
    base = wq.size(); nrd = rcyc.size(); nrv = rvcyc.size();
    send_frame(port, 0);
    check_vec("issue_busy", 64'({s_ready, busy}), 64'(2'b01));
    wait_result(nrv);
    check_frame("port", port, base, nrd, nrv);
    repeat (2) @(negedge clk);
    check_vec("port_idle", 64'({s_ready, busy, r_valid}), 64'(3'b100));

    // Backpressure with random frame; words offered while busy must be ignored.
    for (int k = 0; k < NREG; k++) rf[k] = 16'($urandom);
    r_ready = 1'b0;
    base = wq.size(); nrd = rcyc.size(); nrv = rvcyc.size();
    send_frame(rf, 0);
    wait_result(nrv);
    check_frame("bp", rf, base, nrd, nrv);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 16'($urandom);
      s_last  = 1'($urandom);
      check_vec($sformatf("bp_hold%0d", i), {29'd0, r_valid, s_ready, busy, r_scan, r_data},
                {29'd0, 1'b1, 1'b0, 1'b1, exp_scan_q[nrd], exp_tok_q[nrd]});
      @(negedge clk);
      #1;
    end
    r_ready = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    #1;
    check_vec("bp_release", 64'({r_valid, s_ready, busy}), 64'(3'b010));

    // Short frame (s_last at index 20), then a good random frame with stalls.
    base = wq.size(); e0 = errcnt;
    for (int k = 0; k <= 20; k++) send_word(16'($urandom), k == 20, 0);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (5) @(negedge clk);
    check_int("short_err_cycles", errcnt - e0, 1);
    check_int("short_no_write", wq.size() - base, 0);
    for (int k = 0; k < NREG; k++) rf[k] = 16'($urandom);
    base = wq.size(); nrd = rcyc.size(); nrv = rvcyc.size();
    send_frame(rf, 2);
    wait_result(nrv);
    check_frame("after_short", rf, base, nrd, nrv);
    repeat (2) @(negedge clk);

    // Long frame (34th word without s_last), then portfolio with random gaps.
    base = wq.size(); e0 = errcnt;
    for (int k = 0; k < NREG; k++) send_word(16'($urandom), 1'b0, 0);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_int("long_err_cycles", errcnt - e0, 1);
    check_int("long_no_write", wq.size() - base, 0);
    base = wq.size(); nrd = rcyc.size(); nrv = rvcyc.size();
    send_frame(port, 3);
    wait_result(nrv);
    check_frame("stall", port, base, nrd, nrv);
    repeat (2) @(negedge clk);

    // Reset asserted while write #15 is on the bus.
    for (int k = 0; k < NREG; k++) rf[k] = 16'($urandom);
    base = wq.size(); nrd = rcyc.size(); nrv = rvcyc.size();
    send_frame(rf, 0);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #1;
      if (wq.size() >= base + 15) break;
    end
    check_int("mid_issue_reached", wq.size() - base, 15);
    reset = 1'b1;
    #1;
    check_vec("mid_reset_bus", 64'({write, chipselect, read, s_ready, busy}), 64'(5'b00010));
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    check_int("mid_reset_no_more_writes", wq.size() - base, 15);
    check_int("mid_reset_no_read", rcyc.size() - nrd, 0);
    check_int("mid_reset_no_result", rvcyc.size() - nrv, 0);

    // Recovery: a clean frame after the aborted one.
    base = wq.size(); nrd = rcyc.size(); nrv = rvcyc.size();
    send_frame(port, 0);
    wait_result(nrv);
    check_frame("recover", port, base, nrd, nrv);
    repeat (2) @(negedge clk);

    check_int("bus_protocol_violations", badcnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/span_param_loader.md
Name: span_param_loader

Overview:
- Upstream feeder for span_cme. Accepts one portfolio's SPAN parameter words as a valid/ready stream and buffers the complete frame.
- Replays the frame into span_cme's register interface (offset/write/chipselect), one word per cycle.
- Waits a fixed compute interval, reads the result back, and presents it on a valid/ready result port.
- Replaces hand-sequenced register writes from the host or bench.

Parameters:
- NUM_REGS, 34, words per portfolio frame; written to span_cme offsets 0..NUM_REGS-1.
- DATA_W, 16, data width of the stream, writeData and readData.
- ADDR_W, 6, span_cme offset width.
- CALC_CYCLES, 200, cycles waited after the last write before the result read; legal range 1..65535.
- RESULT_OFFSET, 34, span_cme offset used for the result read.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_data  in  DATA_W  parameter word, two's complement passed through unchanged
- s_valid  in  1  s_data valid
- s_last  in  1  marks the final word of the frame
- s_ready  out  1  loader accepts a word this cycle
- writeData  out  DATA_W  to span_cme
- offset  out  ADDR_W  to span_cme
- write  out  1  to span_cme
- chipselect  out  1  to span_cme
- read  out  1  to span_cme
- readData  in  DATA_W  from span_cme, valid 1 cycle after read
- priceScanRange  in  16  from span_cme
- r_scan  out  16  captured priceScanRange
- r_data  out  DATA_W  captured readData
- r_valid  out  1  result valid
- r_ready  in  1  result consumer ready
- err  out  1  one-cycle pulse on a malformed frame
- busy  out  1  high in every state except LOAD

Behaviour:
- Reset, asynchronous: FSM enters LOAD; word index and wait counter are 0. Outputs reset to s_ready=1, write=0, chipselect=0, read=0, offset=0, writeData=0, r_valid=0, r_scan=0, r_data=0, err=0, busy=0. The buffer contents are don't-care.
- Reset mid-operation: any in-flight write or read drops in the same instant. The partially loaded frame is discarded.
- All outputs are registered.
- LOAD:
  - s_ready=1. A word is accepted on s_valid&s_ready and stored at buffer[idx]; idx increments.
  - If s_last arrives with idx<NUM_REGS-1, or the word at idx==NUM_REGS-1 arrives without s_last: pulse err for 1 cycle, reset idx to 0, stay in LOAD, issue no writes.
  - A valid final word (s_last at idx==NUM_REGS-1) moves the FSM to ISSUE; s_ready drops the following cycle.
- ISSUE:
  - For k=0..NUM_REGS-1 on consecutive cycles: write=1, chipselect=1, offset=k, writeData=buffer[k].
  - Exactly NUM_REGS contiguous write cycles, with no gaps and no repeats.
  - Then go to WAIT with write=chipselect=0.
- WAIT: count CALC_CYCLES cycles, then go to READ.
- READ: one cycle with read=1, chipselect=1, offset=RESULT_OFFSET; write=0.
- CAPTURE: the next cycle samples readData into r_data and priceScanRange into r_scan, then goes to RESULT.
- RESULT:
  - r_valid=1, with r_scan and r_data held stable until r_ready.
  - On r_valid&r_ready: r_valid=0 next cycle and return to LOAD with idx=0.
  - If r_ready is already high on entry, the handshake completes in 1 cycle.
- s_ready=0 in every state except LOAD. Words offered outside LOAD are not consumed.
- Latency: from the final word accepted to the first write is 1 cycle. From the first write to r_valid is NUM_REGS + CALC_CYCLES + 2 cycles.
- No arithmetic is performed on the data. Negative values such as 0xFFF6 pass through bit-exact.

Decomposition:
- span_cme_pkg holds:
  - constants SPAN_NUM_REGS=34, SPAN_DATA_W=16, SPAN_ADDR_W=6, SPAN_RESULT_OFFSET=34;
  - typedef enum loader_state_t {LOAD, ISSUE, WAIT, READ, CAPTURE, RESULT};
  - typedef span_word_t = logic signed [SPAN_DATA_W-1:0].
- Sub-module span_param_buf: NUM_REGS x DATA_W register file with one synchronous write port (LOAD) and one combinational read port indexed by the ISSUE counter.
- FSM, counters and output registers live in span_param_loader.

Test Plan:
- Frame replay: stream the 34-word portfolio (96, 10, 15, 0xFFF6, 0xFFEC, 5, 10, 0, 0, 3, 1, 5, 1, 3, 5, 0, 0, 2, 4, 6, 50, 60, 70, 80, 90, 100, 100, 110, 120, 1750, 2500, 2, 1, 55) with s_last on word 55 -> 34 consecutive write cycles, offset 0..33, writeData matching in order, 0xFFF6 and 0xFFEC bit-exact.
- Result timing: same frame with CALC_CYCLES=200 and r_ready=1 -> read pulses exactly 200 cycles after the last write, at offset 34. r_valid rises 2 cycles after the read pulse, with r_scan equal to priceScanRange at capture.
- Backpressure: hold r_ready=0 for 10 cycles after r_valid -> r_valid, r_scan and r_data stay stable, s_ready=0 throughout. Raising r_ready completes the handshake, after which s_ready=1.
- Short and long frames:
  - s_last on word index 20 -> err pulses for 1 cycle and no write occurs; a following good frame loads normally.
  - 34th word without s_last -> same err response.
- Reset mid-ISSUE: assert reset at write #15 -> write, chipselect and read go to 0 immediately, the FSM returns to LOAD with s_ready=1, and no further writes occur.
- Input stall: insert random s_valid gaps during LOAD -> the buffer captures the words in order and the ISSUE output is identical to the scenario 1 sequence.
